// File: rtl/fetch_stage.sv
// fetch_stage: PC generation and instruction fetch with a small output FIFO.
// Drives imem combinationally from the PC register, buffers fetched words,
// and hands them to decode over valid/ready. Redirects flush the FIFO; any
// fetch exception (imem fault or misaligned PC) halts fetch until the next
// redirect.
// Optional feature macro: FETCH_PERF_EN adds saturating perf_fetched and
// perf_bubbles counters.
module fetch_stage #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [63:0] pc_addr,
  input  logic [31:0] imem_instr,
  input  logic        imem_exc_en,
  input  logic [3:0]  imem_exc_code,
  input  logic [63:0] imem_exc_val,
  input  logic        redirect_en,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_exc_en,
  output logic [3:0]  out_exc_code,
  output logic [63:0] out_exc_val
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_bubbles
`endif
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW = AW + 1;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } state_e;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        exc_en;
    logic [3:0]  exc_code;
    logic [63:0] exc_val;
  } entry_t;

  state_e        state_q, state_d;
  logic [63:0]   pc_q, pc_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  entry_t        mem_q [DEPTH];

  logic          empty_c;
  logic          full_c;
  logic          pop_c;
  logic          push_c;
  logic          misalign_c;
  entry_t        wr_entry_c;
  entry_t        head_c;

  // FIFO status and handshake decode
  always_comb begin
    empty_c = (wr_ptr_q == rd_ptr_q);
    full_c  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    pop_c   = !empty_c && out_ready;
    push_c  = (state_q == FETCH) && (!full_c || pop_c) && !redirect_en;
  end

  // Entry to push: misaligned PC takes precedence over imem data
  always_comb begin
    misalign_c          = (pc_q[1:0] != 2'b00);
    wr_entry_c.pc       = pc_q;
    wr_entry_c.instr    = imem_instr;
    wr_entry_c.exc_en   = imem_exc_en;
    wr_entry_c.exc_code = imem_exc_code;
    wr_entry_c.exc_val  = imem_exc_val;
    if (misalign_c) begin
      wr_entry_c.instr    = NOP_INSTR;
      wr_entry_c.exc_en   = 1'b1;
      wr_entry_c.exc_code = 4'd0;
      wr_entry_c.exc_val  = pc_q;
    end else if (imem_exc_en) begin
      wr_entry_c.instr = NOP_INSTR;
    end
  end

  // Next-state logic: redirect flushes and overrides push/pop
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (redirect_en) begin
      pc_d     = redirect_pc;
      state_d  = FETCH;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (pop_c) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (push_c) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
        if (wr_entry_c.exc_en) begin
          state_d = HALT;
        end else begin
          pc_d = pc_q + 64'd4;
        end
      end
    end
  end

  // Control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // FIFO storage; contents are don't-care while the pointers mark it empty
  always_ff @(posedge clk) begin
    if (!rst && push_c) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_entry_c;
    end
  end

  // Head outputs, forced to zero when empty
  always_comb begin
    head_c       = mem_q[rd_ptr_q[AW-1:0]];
    pc_addr      = pc_q;
    out_valid    = !empty_c;
    out_pc       = empty_c ? 64'd0 : head_c.pc;
    out_instr    = empty_c ? 32'd0 : head_c.instr;
    out_exc_en   = empty_c ? 1'b0  : head_c.exc_en;
    out_exc_code = empty_c ? 4'd0  : head_c.exc_code;
    out_exc_val  = empty_c ? 64'd0 : head_c.exc_val;
  end

`ifdef FETCH_PERF_EN
  logic [31:0] fetched_q, fetched_d;
  logic [31:0] bubbles_q, bubbles_d;

  // Saturating counters; redirect does not clear them
  always_comb begin
    fetched_d = fetched_q;
    bubbles_d = bubbles_q;
    if (push_c && (fetched_q != 32'hFFFF_FFFF)) begin
      fetched_d = fetched_q + 32'd1;
    end
    if (empty_c && (state_q == FETCH) && (bubbles_q != 32'hFFFF_FFFF)) begin
      bubbles_d = bubbles_q + 32'd1;
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      fetched_q <= 32'd0;
      bubbles_q <= 32'd0;
    end else begin
      fetched_q <= fetched_d;
      bubbles_q <= bubbles_d;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_bubbles = bubbles_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage with a behavioural imem model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] pc_addr;
  logic [31:0] imem_instr;
  logic        imem_exc_en;
  logic [3:0]  imem_exc_code;
  logic [63:0] imem_exc_val;
  logic        redirect_en;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        out_exc_en;
  logic [3:0]  out_exc_code;
  logic [63:0] out_exc_val;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_bubbles;
`endif

  logic        exc_arm;
  logic [63:0] exc_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // imem model: two fixed words at 0 and 4, a tagged address elsewhere
  function automatic logic [31:0] imem_word(input logic [63:0] a);
    if (a == 64'd0) return 32'h0050_0093;
    if (a == 64'd4) return 32'h00A0_0113;
    return a[31:0] ^ 32'hC0DE_0000;
  endfunction

  assign imem_instr    = imem_word(pc_addr);
  assign imem_exc_en   = exc_arm && (pc_addr == exc_addr);
  assign imem_exc_code = 4'd1;
  assign imem_exc_val  = pc_addr;

  fetch_stage #(.RESET_PC(64'h0), .DEPTH(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_addr       (pc_addr),
    .imem_instr    (imem_instr),
    .imem_exc_en   (imem_exc_en),
    .imem_exc_code (imem_exc_code),
    .imem_exc_val  (imem_exc_val),
    .redirect_en   (redirect_en),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_instr     (out_instr),
    .out_exc_en    (out_exc_en),
    .out_exc_code  (out_exc_code),
    .out_exc_val   (out_exc_val)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched  (perf_fetched),
    .perf_bubbles  (perf_bubbles)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst         = 1'b1;
    out_ready   = 1'b1;
    redirect_en = 1'b0;
    redirect_pc = 64'd0;
    exc_arm     = 1'b0;
    exc_addr    = 64'd0;

    // Reset state
    tick(); tick();
    rst = 1'b0;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_pc",    out_pc, 64'd0);
    check("rst_instr", 64'(out_instr), 64'd0);
    check("rst_exc",   64'(out_exc_en), 64'd0);
    check("rst_pcaddr", pc_addr, 64'd0);

    // Streaming fetch at one instruction per cycle
    tick();
    check("s1_valid", 64'(out_valid), 64'd1);
    check("s1_pc",    out_pc, 64'd0);
    check("s1_instr", 64'(out_instr), 64'h0050_0093);
    check("s1_pcaddr", pc_addr, 64'd4);
    tick();
    check("s2_pc",    out_pc, 64'd4);
    check("s2_instr", 64'(out_instr), 64'h00A0_0113);
    check("s2_pcaddr", pc_addr, 64'd8);

    // Backpressure from reset for 5 cycles
    rst = 1'b1; out_ready = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("bp_pcaddr", pc_addr, 64'd8);
    check("bp_valid",  64'(out_valid), 64'd1);
    check("bp_head",   out_pc, 64'd0);
    out_ready = 1'b1;
    tick();
    check("bp_rel1_pc", out_pc, 64'd4);
    check("bp_rel1_pcaddr", pc_addr, 64'd12);
    tick();
    check("bp_rel2_pc", out_pc, 64'd8);
    check("bp_rel2_instr", 64'(out_instr), 64'hC0DE_0008);
    tick();
    check("bp_rel3_pc", out_pc, 64'd12);

    // imem fault at 0x2000 halts fetch
    exc_arm = 1'b1; exc_addr = 64'h2000;
    redirect_en = 1'b1; redirect_pc = 64'h1FF8;
    tick();
    redirect_en = 1'b0;
    check("ex_redir_valid", 64'(out_valid), 64'd0);
    check("ex_redir_pcaddr", pc_addr, 64'h1FF8);
    tick();
    check("ex_a_pc", out_pc, 64'h1FF8);
    tick();
    check("ex_b_pc", out_pc, 64'h1FFC);
    tick();
    check("ex_pc",    out_pc, 64'h2000);
    check("ex_instr", 64'(out_instr), 64'h13);
    check("ex_en",    64'(out_exc_en), 64'd1);
    check("ex_code",  64'(out_exc_code), 64'd1);
    check("ex_val",   out_exc_val, 64'h2000);
    check("ex_pcaddr", pc_addr, 64'h2000);
    tick();
    check("ex_halt_valid", 64'(out_valid), 64'd0);
    tick();
    check("ex_halt_valid2", 64'(out_valid), 64'd0);
    check("ex_halt_pcaddr", pc_addr, 64'h2000);
    redirect_en = 1'b1; redirect_pc = 64'h100;
    tick();
    redirect_en = 1'b0;
    check("ex_resume_pcaddr", pc_addr, 64'h100);
    tick();
    check("ex_resume_pc", out_pc, 64'h100);
    check("ex_resume_exc", 64'(out_exc_en), 64'd0);

    // Redirect while full with a same-cycle pop
    out_ready = 1'b0;
    tick(); tick();
    check("fr_full_pcaddr", pc_addr, 64'h108);
    out_ready = 1'b1; redirect_en = 1'b1; redirect_pc = 64'h40;
    tick();
    redirect_en = 1'b0;
    check("fr_valid", 64'(out_valid), 64'd0);
    check("fr_pcaddr", pc_addr, 64'h40);
    tick();
    check("fr_head_valid", 64'(out_valid), 64'd1);
    check("fr_head_pc", out_pc, 64'h40);

    // Misaligned redirect
    out_ready = 1'b0; redirect_en = 1'b1; redirect_pc = 64'h42;
    tick();
    redirect_en = 1'b0;
    check("ma_valid0", 64'(out_valid), 64'd0);
    check("ma_pcaddr0", pc_addr, 64'h42);
    tick();
    check("ma_valid", 64'(out_valid), 64'd1);
    check("ma_pc",    out_pc, 64'h42);
    check("ma_instr", 64'(out_instr), 64'h13);
    check("ma_en",    64'(out_exc_en), 64'd1);
    check("ma_code",  64'(out_exc_code), 64'd0);
    check("ma_val",   out_exc_val, 64'h42);
    check("ma_pcaddr", pc_addr, 64'h42);
    tick();
    check("ma_hold_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    tick();
    check("ma_drained", 64'(out_valid), 64'd0);
    tick();
    check("ma_halted", 64'(out_valid), 64'd0);

    // 64-bit PC wrap
    redirect_en = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    redirect_en = 1'b0;
    tick();
    check("wrap_head", out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_pcaddr", pc_addr, 64'd0);
    tick();
    check("wrap_next", out_pc, 64'd0);

`ifdef FETCH_PERF_EN
    // Performance counters
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("perf_rst_f", 64'(perf_fetched), 64'd0);
    check("perf_rst_b", 64'(perf_bubbles), 64'd0);
    for (int i = 0; i < 10; i++) tick();
    check("perf_fetched", 64'(perf_fetched), 64'd10);
    check("perf_bubbles", 64'(perf_bubbles), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("perf_clr_f", 64'(perf_fetched), 64'd0);
    check("perf_clr_b", 64'(perf_bubbles), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
